// File: rtl/calendar_field_counter_if.sv
// Handshake bundle for one calendar field counter: control/load inputs and
// count/carry/boundary outputs.
interface calendar_field_counter_if #(
    parameter int WIDTH = 12
);
    logic             ctrl_set;
    logic             inc;
    logic             dec;
    logic             carry_in;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_dyn;
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             at_max;
    logic             at_min;

    modport master (
        output ctrl_set, inc, dec, carry_in, load, load_val, max_dyn,
        input  count, carry_out, at_max, at_min
    );

    modport slave (
        input  ctrl_set, inc, dec, carry_in, load, load_val, max_dyn,
        output count, carry_out, at_max, at_min
    );
endinterface

// File: rtl/calendar_field_counter.sv
// Bounded up/down counter for one calendar field with dynamic upper bound,
// set-mode wrap/saturate, clamped load and a registered run-mode carry pulse.
module calendar_field_counter #(
    parameter int WIDTH       = 12,
    parameter int MIN_VAL     = 2025,
    parameter int MAX_VAL     = 3025,
    parameter int RESET_VAL   = 2025,
    parameter bit SET_WRAP    = 1'b1,
    parameter bit USE_DYN_MAX = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    calendar_field_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] dyn_cap_s;
    logic [WIDTH-1:0] eff_max_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic             carry_r;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] hi);
        logic [WIDTH-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Effective upper bound: optional dynamic cap, never below the minimum.
    always_comb begin
        dyn_cap_s = MAX_V;
        eff_max_s = MAX_V;
        if (USE_DYN_MAX && (bus.max_dyn < MAX_V)) begin
            dyn_cap_s = bus.max_dyn;
        end else begin
            dyn_cap_s = MAX_V;
        end
        if (dyn_cap_s < MIN_V) begin
            eff_max_s = MIN_V;
        end else begin
            eff_max_s = dyn_cap_s;
        end
    end

    // Next-state selection in priority order; every path ends inside [MIN, eff_max].
    always_comb begin
        count_nxt_s = count_r;
        carry_nxt_s = 1'b0;
        if (bus.load) begin
            count_nxt_s = clamp(bus.load_val, MIN_V, eff_max_s);
        end else if (bus.ctrl_set && bus.inc) begin
            if (count_r >= eff_max_s) begin
                count_nxt_s = SET_WRAP ? MIN_V : eff_max_s;
            end else begin
                count_nxt_s = count_r + ONE_V;
            end
        end else if (bus.ctrl_set && bus.dec) begin
            if (count_r <= MIN_V) begin
                count_nxt_s = SET_WRAP ? eff_max_s : MIN_V;
            end else begin
                // A shrunken bound may leave count-1 still above it.
                count_nxt_s = clamp(count_r - ONE_V, MIN_V, eff_max_s);
            end
        end else if (bus.ctrl_set) begin
            count_nxt_s = clamp(count_r, MIN_V, eff_max_s);
        end else if (bus.carry_in) begin
            if (count_r >= eff_max_s) begin
                count_nxt_s = MIN_V;
                carry_nxt_s = 1'b1;
            end else begin
                count_nxt_s = count_r + ONE_V;
            end
        end else begin
            count_nxt_s = clamp(count_r, MIN_V, eff_max_s);
        end
    end

    // Count and carry registers; reset clears any pending carry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= RESET_V;
            carry_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    assign bus.count     = count_r;
    assign bus.carry_out = carry_r;
    assign bus.at_max    = (count_r == eff_max_s);
    assign bus.at_min    = (count_r == MIN_V);
endmodule

// File: tb/tb_calendar_field_counter.sv
// Scoreboard bench: three field configurations (year wrap, year saturate, day
// with dynamic bound) driven together and checked against an integer model.
module tb_calendar_field_counter;
    logic clk;
    logic rst_n;

    typedef struct {
        int cnt;
        bit co;
        bit amax;
        bit amin;
    } exp_t;

    exp_t q_y[$];
    exp_t q_s[$];
    exp_t q_d[$];

    int errors = 0;
    int checks = 0;
    int m_y, m_s, m_d;
    int md_cur;

    calendar_field_counter_if #(.WIDTH(12)) bus_y ();
    calendar_field_counter_if #(.WIDTH(12)) bus_s ();
    calendar_field_counter_if #(.WIDTH(5))  bus_d ();

    calendar_field_counter #(.WIDTH(12), .MIN_VAL(2025), .MAX_VAL(3025), .RESET_VAL(2025),
                             .SET_WRAP(1'b1), .USE_DYN_MAX(1'b0))
        u_y (.clk(clk), .rst_n(rst_n), .bus(bus_y));
    calendar_field_counter #(.WIDTH(12), .MIN_VAL(2025), .MAX_VAL(3025), .RESET_VAL(2500),
                             .SET_WRAP(1'b0), .USE_DYN_MAX(1'b0))
        u_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    calendar_field_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1),
                             .SET_WRAP(1'b1), .USE_DYN_MAX(1'b1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of a field counter from the rule list.
    function automatic exp_t step(inout int c, input int minv, input int maxv,
                                  input bit wrap, input bit usedyn, input int md,
                                  input bit s, input bit i, input bit d, input bit ci,
                                  input bit ld, input int lv);
        exp_t e;
        int emax;
        bit co;
        emax = maxv;
        if (usedyn && md < maxv) emax = md;
        if (emax < minv) emax = minv;
        co = 1'b0;
        if (ld)                c = (lv < minv) ? minv : ((lv > emax) ? emax : lv);
        else if (s && i)       c = (c >= emax) ? (wrap ? minv : emax) : c + 1;
        else if (s && d)       c = (c <= minv) ? (wrap ? emax : minv) : ((c - 1 > emax) ? emax : c - 1);
        else if (s)            c = (c > emax) ? emax : c;
        else if (ci) begin
            if (c >= emax) begin c = minv; co = 1'b1; end
            else c = c + 1;
        end
        else                   c = (c > emax) ? emax : c;
        e.cnt  = c;
        e.co   = co;
        e.amax = (c == emax);
        e.amin = (c == minv);
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue expectations.
    task automatic cyc(input bit s, input bit i, input bit d, input bit ci, input bit ld,
                       input int lvy, input int lvd, input int mdd);
        @(negedge clk);
        md_cur = mdd;
        bus_y.ctrl_set = s; bus_y.inc = i; bus_y.dec = d; bus_y.carry_in = ci; bus_y.load = ld;
        bus_y.load_val = 12'(lvy); bus_y.max_dyn = 12'($urandom);
        bus_s.ctrl_set = s; bus_s.inc = i; bus_s.dec = d; bus_s.carry_in = ci; bus_s.load = ld;
        bus_s.load_val = 12'(lvy); bus_s.max_dyn = 12'($urandom);
        bus_d.ctrl_set = s; bus_d.inc = i; bus_d.dec = d; bus_d.carry_in = ci; bus_d.load = ld;
        bus_d.load_val = 5'(lvd); bus_d.max_dyn = 5'(mdd);
        q_y.push_back(step(m_y, 2025, 3025, 1'b1, 1'b0, 0, s, i, d, ci, ld, lvy));
        q_s.push_back(step(m_s, 2025, 3025, 1'b0, 1'b0, 0, s, i, d, ci, ld, lvy));
        q_d.push_back(step(m_d, 1, 31, 1'b1, 1'b1, mdd, s, i, d, ci, ld, lvd));
    endtask

    task automatic idle_inputs();
        bus_y.ctrl_set = 1'b0; bus_y.inc = 1'b0; bus_y.dec = 1'b0; bus_y.carry_in = 1'b0;
        bus_y.load = 1'b0; bus_y.load_val = 12'd0; bus_y.max_dyn = 12'd0;
        bus_s.ctrl_set = 1'b0; bus_s.inc = 1'b0; bus_s.dec = 1'b0; bus_s.carry_in = 1'b0;
        bus_s.load = 1'b0; bus_s.load_val = 12'd0; bus_s.max_dyn = 12'd0;
        bus_d.ctrl_set = 1'b0; bus_d.inc = 1'b0; bus_d.dec = 1'b0; bus_d.carry_in = 1'b0;
        bus_d.load = 1'b0; bus_d.load_val = 5'd0; bus_d.max_dyn = 5'(md_cur);
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) begin
            if (q_y.size() == 0 && q_s.size() == 0 && q_d.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("drain_timeout", q_y.size() + q_s.size() + q_d.size(), 0);
    endtask

    task automatic cmp(input string nm, input exp_t e, input int c, input bit co,
                       input bit amax, input bit amin);
        chk({nm, "_count"}, c, e.cnt);
        chk({nm, "_carry_out"}, int'(co), int'(e.co));
        chk({nm, "_at_max"}, int'(amax), int'(e.amax));
        chk({nm, "_at_min"}, int'(amin), int'(e.amin));
    endtask

    // Monitor: one result per clock edge, compared shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_y.size() != 0) cmp("year", q_y.pop_front(), int'(bus_y.count), bus_y.carry_out, bus_y.at_max, bus_y.at_min);
            if (q_s.size() != 0) cmp("sat",  q_s.pop_front(), int'(bus_s.count), bus_s.carry_out, bus_s.at_max, bus_s.at_min);
            if (q_d.size() != 0) cmp("day",  q_d.pop_front(), int'(bus_d.count), bus_d.carry_out, bus_d.at_max, bus_d.at_min);
        end
    end

    initial begin
        md_cur = 31;
        idle_inputs();
        rst_n = 1'b0;
        m_y = 2025; m_s = 2500; m_d = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_year_count", int'(bus_y.count), 2025);
        chk("reset_sat_count", int'(bus_s.count), 2500);
        chk("reset_day_count", int'(bus_d.count), 1);
        chk("reset_carry", int'(bus_y.carry_out | bus_s.carry_out | bus_d.carry_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three run-mode advances.
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 31);
        drain();
        chk("t1_year_count", int'(bus_y.count), 2028);

        // Run-mode wrap produces a single carry pulse.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3025, 31, 31);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 31);
        drain();
        chk("t2_wrap_count", int'(bus_y.count), 2025);
        chk("t2_carry_high", int'(bus_y.carry_out), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 31);
        drain();
        chk("t2_carry_low", int'(bus_y.carry_out), 0);

        // Set-mode decrement at the minimum: wrap vs saturate.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2025, 1, 31);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 31);
        drain();
        chk("t3_wrap_dec", int'(bus_y.count), 3025);
        chk("t3_sat_dec", int'(bus_s.count), 2025);
        chk("t3_sat_at_min", int'(bus_s.at_min), 1);

        // Month change shrinks the day bound.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2100, 31, 31);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 30);
        drain();
        chk("t4_day_shrink", int'(bus_d.count), 30);
        chk("t4_day_at_max", int'(bus_d.at_max), 1);

        // inc beats dec, carry_in ignored in set mode; load clamps high.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 30);
        drain();
        chk("t5_inc_wins", int'(bus_y.count), 2101);
        chk("t5_no_carry", int'(bus_y.carry_out), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4000, 31, 30);
        drain();
        chk("t5_load_clamp", int'(bus_y.count), 3025);

        // Asynchronous reset during the carry cycle.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3025, 5, 31);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 31);
        drain();
        chk("t6_pre_carry", int'(bus_s.carry_out), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_sat_count", int'(bus_s.count), 2500);
        chk("t6_sat_carry", int'(bus_s.carry_out), 0);
        chk("t6_year_carry", int'(bus_y.carry_out), 0);
        m_y = 2025; m_s = 2500; m_d = 1;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int md;
            md = md_cur;
            if ($urandom_range(0, 19) == 0) md = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(28, 31);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                $urandom_range(0, 4095), $urandom_range(0, 31), md);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
